// File: rtl/ap_ctrl_txn_recorder.sv
// ---------------------------------------------------------------------------
// ap_ctrl_txn_recorder
//
// Watches the ap_start / ap_done / ap_continue handshake of an ap_ctrl_hs
// block. For every transaction it records:
//   - the start timestamp,
//   - the latency from start to the first ap_done,
//   - a 16-bit sequence id.
// Records are queued in a small FIFO for a downstream consumer.
//
// Optional feature (macro AP_CTRL_TXN_RECORDER_INTERVAL_EN):
//   Adds a rec_interval output. It is the start-to-start distance from the
//   previous transaction and is stored per FIFO entry.
//
// Parameters
//   TS_W   width of timestamp / latency / interval fields
//   DEPTH  record FIFO depth (power of 2, >= 2)
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   ap_start, ap_done,    observed handshake
//   ap_continue
//   rec_ready             consumer accepts the head record
//   rec_valid             head record present
//   rec_start_ts          head record start timestamp
//   rec_latency           head record latency
//   rec_id                head record sequence id
//   rec_interval          head record start interval (macro builds only)
//   busy                  a transaction is in flight (RUN or HOLD)
//   drop_cnt              saturating count of records lost to a full FIFO
// ---------------------------------------------------------------------------
module ap_ctrl_txn_recorder #(
    parameter int TS_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ap_start,
    input  logic            ap_done,
    input  logic            ap_continue,
    input  logic            rec_ready,
    output logic            rec_valid,
    output logic [TS_W-1:0] rec_start_ts,
    output logic [TS_W-1:0] rec_latency,
    output logic [15:0]     rec_id,
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
    output logic [TS_W-1:0] rec_interval,
`endif
    output logic            busy,
    output logic [15:0]     drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [TS_W-1:0] ts_r, start_ts_r, latency_r;
    logic [15:0]     txn_id_r, drop_cnt_r;
    logic            push_s, cap_start_s, cap_lat_s;
    logic [TS_W-1:0] start_s, lat_s;

    logic [TS_W-1:0] start_mem_r [DEPTH];
    logic [TS_W-1:0] lat_mem_r   [DEPTH];
    logic [15:0]     id_mem_r    [DEPTH];
    logic [AW:0]     wr_ptr_r, rd_ptr_r;
    logic            empty_s, full_s, pop_s, accept_s, drop_s;
    logic [AW-1:0]   rd_idx_s, wr_idx_s;

`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
    logic [TS_W-1:0] prev_start_r, interval_r, interval_new_s, interval_push_s;
    logic            first_r;
    logic [TS_W-1:0] ivl_mem_r [DEPTH];
`endif

    assign busy     = (state_r != ST_IDLE);
    assign drop_cnt = drop_cnt_r;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state plus the record fields to push this cycle.
    // In HOLD the fields come from the frozen registers.
    always_comb begin
        state_s     = state_r;
        push_s      = 1'b0;
        cap_start_s = 1'b0;
        cap_lat_s   = 1'b0;
        start_s     = start_ts_r;
        lat_s       = latency_r;
        case (state_r)
            ST_IDLE: begin
                if (ap_start) begin
                    cap_start_s = 1'b1;
                    start_s     = ts_r;
                    if (ap_done) begin
                        cap_lat_s = 1'b1;
                        lat_s     = {TS_W{1'b0}};
                        if (ap_continue) begin
                            push_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_HOLD;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ap_done) begin
                    cap_lat_s = 1'b1;
                    lat_s     = ts_r - start_ts_r;
                    if (ap_continue) begin
                        push_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (ap_continue) begin
                    push_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Timestamp, capture registers, id counter and saturating drop counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_r       <= {TS_W{1'b0}};
            start_ts_r <= {TS_W{1'b0}};
            latency_r  <= {TS_W{1'b0}};
            txn_id_r   <= 16'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            ts_r <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
            if (cap_start_s) begin
                start_ts_r <= ts_r;
            end
            if (cap_lat_s) begin
                latency_r <= lat_s;
            end
            // Dropped records still consume an id.
            if (push_s) begin
                txn_id_r <= txn_id_r + 16'd1;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
    // The first start after reset has no predecessor, so its interval is 0.
    assign interval_new_s  = first_r ? {TS_W{1'b0}} : (ts_r - prev_start_r);
    // Same-cycle start+push uses the freshly computed interval.
    assign interval_push_s = cap_start_s ? interval_new_s : interval_r;

    // Previous-start tracking for the interval field
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_start_r <= {TS_W{1'b0}};
            interval_r   <= {TS_W{1'b0}};
            first_r      <= 1'b1;
        end else begin
            if (cap_start_s) begin
                prev_start_r <= ts_r;
                interval_r   <= interval_new_s;
                first_r      <= 1'b0;
            end
        end
    end
`endif

    // FIFO control.
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign rd_idx_s  = rd_ptr_r[AW-1:0];
    assign wr_idx_s  = wr_ptr_r[AW-1:0];
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_idx_s == rd_idx_s);
    assign rec_valid = ~empty_s;
    assign pop_s     = rec_valid & rec_ready;
    assign accept_s  = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & full_s & ~pop_s;

    // FIFO read/write pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Record storage.
    // No reset is needed: outputs are gated by rec_valid.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            start_mem_r[wr_idx_s] <= start_s;
            lat_mem_r[wr_idx_s]   <= lat_s;
            id_mem_r[wr_idx_s]    <= txn_id_r;
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
            ivl_mem_r[wr_idx_s]   <= interval_push_s;
`endif
        end
    end

    // Head record presentation, zero when the FIFO is empty
    always_comb begin
        if (rec_valid) begin
            rec_start_ts = start_mem_r[rd_idx_s];
            rec_latency  = lat_mem_r[rd_idx_s];
            rec_id       = id_mem_r[rd_idx_s];
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
            rec_interval = ivl_mem_r[rd_idx_s];
`endif
        end else begin
            rec_start_ts = {TS_W{1'b0}};
            rec_latency  = {TS_W{1'b0}};
            rec_id       = 16'd0;
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
            rec_interval = {TS_W{1'b0}};
`endif
        end
    end

endmodule

// File: tb/tb_ap_ctrl_txn_recorder.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_txn_recorder
//
// Directed bench for ap_ctrl_txn_recorder.
//   u_dut   default build (TS_W=32, DEPTH=4)
//   u_dut8  TS_W=8 instance sharing the same stimulus, for timestamp wrap
//
// Inputs are driven 1 time unit after the rising edge and sampled there too.
// Every DUT output comes from registers.
// tb_ts mirrors the free-running timestamp: it is 0 in the first cycle after
// reset release.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_txn_recorder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_continue = 1'b1;
    logic        rec_ready = 1'b0;

    logic        rec_valid, busy;
    logic [31:0] rec_start_ts, rec_latency;
    logic [15:0] rec_id, drop_cnt;
    logic        rec8_valid, busy8;
    logic [7:0]  rec8_start_ts, rec8_latency;
    logic [15:0] rec8_id, drop8_cnt;
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
    logic [31:0] rec_interval;
    logic [7:0]  rec8_interval;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int tb_ts    = 0;

    always #5 clock = ~clock;

    ap_ctrl_txn_recorder #(.TS_W(32), .DEPTH(4)) u_dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
        .ap_continue(ap_continue), .rec_ready(rec_ready), .rec_valid(rec_valid),
        .rec_start_ts(rec_start_ts), .rec_latency(rec_latency), .rec_id(rec_id),
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
        .rec_interval(rec_interval),
`endif
        .busy(busy), .drop_cnt(drop_cnt)
    );

    ap_ctrl_txn_recorder #(.TS_W(8), .DEPTH(4)) u_dut8 (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
        .ap_continue(ap_continue), .rec_ready(rec_ready), .rec_valid(rec8_valid),
        .rec_start_ts(rec8_start_ts), .rec_latency(rec8_latency), .rec_id(rec8_id),
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
        .rec_interval(rec8_interval),
`endif
        .busy(busy8), .drop_cnt(drop8_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        tb_ts++;
    endtask

    task automatic to_ts(input int n);
        while (tb_ts < n) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ap_start = 1'b0;
        ap_done  = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tb_ts = 0;
    endtask

    // Start now. ap_done comes three cycles later, so latency is 3.
    task automatic run3();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rec_ready = 1'b1;
        ap_continue = 1'b1;
        @(posedge clock);
        #1;
        check("rst_valid", {31'd0, rec_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        check("rst_id", {16'd0, rec_id}, 32'd0);
        check("rst_start", rec_start_ts, 32'd0);
        check("rst_lat", rec_latency, 32'd0);

        // -------- start at ts 5, done at ts 12, continue=1 --------
        do_reset();
        to_ts(5);
        ap_start = 1'b1;
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        ap_start = 1'b0;
        check("t1_run_busy", {31'd0, busy}, 32'd1);
        to_ts(12);
        check("t1_no_rec_yet", {31'd0, rec_valid}, 32'd0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t1_valid", {31'd0, rec_valid}, 32'd1);
        check("t1_start", rec_start_ts, 32'd5);
        check("t1_lat", rec_latency, 32'd7);
        check("t1_id", {16'd0, rec_id}, 32'd0);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        tick();
        check("t1_popped", {31'd0, rec_valid}, 32'd0);

        // -------- done at ts 12, continue held low until ts 15 --------
        rec_ready = 1'b0;
        ap_continue = 1'b0;
        do_reset();
        to_ts(5);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        to_ts(12);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t2_hold_busy", {31'd0, busy}, 32'd1);
        check("t2_hold_novalid", {31'd0, rec_valid}, 32'd0);
        to_ts(15);
        check("t2_busy_ts15", {31'd0, busy}, 32'd1);
        check("t2_novalid_ts15", {31'd0, rec_valid}, 32'd0);
        ap_continue = 1'b1;
        tick();
        check("t2_valid", {31'd0, rec_valid}, 32'd1);
        check("t2_lat", rec_latency, 32'd7);
        check("t2_start", rec_start_ts, 32'd5);
        check("t2_busy_low", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check("t2_stable_start", rec_start_ts, 32'd5);
        check("t2_stable_valid", {31'd0, rec_valid}, 32'd1);

        // -------- six transactions into a stalled FIFO of depth 4 --------
        rec_ready = 1'b0;
        ap_continue = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) run3();
        check("t3_drop", {16'd0, drop_cnt}, 32'd2);
        check("t3_head_id", {16'd0, rec_id}, 32'd0);
        check("t3_head_start", rec_start_ts, 32'd0);
        check("t3_head_lat", rec_latency, 32'd3);
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
        check("t3_head_ivl", rec_interval, 32'd0);
`endif
        rec_ready = 1'b1;
        tick();
        check("t3_id1", {16'd0, rec_id}, 32'd1);
        check("t3_start1", rec_start_ts, 32'd4);
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
        check("t3_ivl1", rec_interval, 32'd4);
`endif
        tick();
        check("t3_id2", {16'd0, rec_id}, 32'd2);
        check("t3_start2", rec_start_ts, 32'd8);
        tick();
        check("t3_id3", {16'd0, rec_id}, 32'd3);
        check("t3_start3", rec_start_ts, 32'd12);
        tick();
        check("t3_empty", {31'd0, rec_valid}, 32'd0);

        // -------- full FIFO with a push and a pop in the same cycle --------
        rec_ready = 1'b0;
        for (int i = 0; i < 4; i++) run3();        // ids 6..9, starts 28..40
        check("t4_full_head", {16'd0, rec_id}, 32'd6);
        ap_start = 1'b1;                           // id 10, start 44
        tick();
        ap_start = 1'b0;
        tick();
        tick();
        ap_done = 1'b1;
        rec_ready = 1'b1;
        tick();
        ap_done = 1'b0;
        rec_ready = 1'b0;
        check("t4_valid", {31'd0, rec_valid}, 32'd1);
        check("t4_head_id", {16'd0, rec_id}, 32'd7);
        check("t4_head_start", rec_start_ts, 32'd32);
        check("t4_drop_same", {16'd0, drop_cnt}, 32'd2);
        rec_ready = 1'b1;
        tick();
        check("t4_id8", {16'd0, rec_id}, 32'd8);
        tick();
        check("t4_id9", {16'd0, rec_id}, 32'd9);
        tick();
        check("t4_id10", {16'd0, rec_id}, 32'd10);
        check("t4_start10", rec_start_ts, 32'd44);
        check("t4_lat10", rec_latency, 32'd3);
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
        check("t4_ivl10", rec_interval, 32'd4);
`endif
        tick();
        check("t4_empty", {31'd0, rec_valid}, 32'd0);
        // Pop requests on an empty FIFO must do nothing.
        tick();
        tick();
        check("t4_empty_pop_valid", {31'd0, rec_valid}, 32'd0);
        check("t4_empty_pop_drop", {16'd0, drop_cnt}, 32'd2);
        run3();                                    // id 11, start 54
        check("t4_after_empty_valid", {31'd0, rec_valid}, 32'd1);
        check("t4_after_empty_id", {16'd0, rec_id}, 32'd11);
        check("t4_after_empty_start", rec_start_ts, 32'd54);

        // -------- same-cycle start+done, back-to-back start, HOLD --------
        rec_ready = 1'b0;
        ap_continue = 1'b1;
        do_reset();
        to_ts(3);
        ap_start = 1'b1;
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;                            // ap_start stays high
        check("t5_zero_valid", {31'd0, rec_valid}, 32'd1);
        check("t5_zero_lat", rec_latency, 32'd0);
        check("t5_zero_start", rec_start_ts, 32'd3);
        check("t5_zero_busy", {31'd0, busy}, 32'd0);
        tick();                                    // restarted at ts 4
        ap_start = 1'b0;
        check("t5_b2b_busy", {31'd0, busy}, 32'd1);
        ap_done = 1'b1;
        ap_continue = 1'b0;
        tick();                                    // done at ts 5 -> HOLD
        ap_done = 1'b0;
        check("t5_hold_busy", {31'd0, busy}, 32'd1);
        ap_continue = 1'b1;
        tick();                                    // push id 1
        rec_ready = 1'b1;
        check("t5_head_still0", {16'd0, rec_id}, 32'd0);
        tick();
        check("t5_id1", {16'd0, rec_id}, 32'd1);
        check("t5_start1", rec_start_ts, 32'd4);
        check("t5_lat1", rec_latency, 32'd1);
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
        check("t5_ivl1", rec_interval, 32'd1);
`endif

        // -------- reset pulsed in RUN with two records queued --------
        rec_ready = 1'b0;
        do_reset();
        run3();
        run3();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("t6_pre_busy", {31'd0, busy}, 32'd1);
        check("t6_pre_valid", {31'd0, rec_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, rec_valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_drop", {16'd0, drop_cnt}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tb_ts = 0;
        check("t6_post_valid", {31'd0, rec_valid}, 32'd0);
        run3();
        check("t6_new_valid", {31'd0, rec_valid}, 32'd1);
        check("t6_new_id", {16'd0, rec_id}, 32'd0);
        check("t6_new_start", rec_start_ts, 32'd0);
`ifdef AP_CTRL_TXN_RECORDER_INTERVAL_EN
        check("t6_new_ivl", rec_interval, 32'd0);
`endif

        // -------- TS_W=8 wrap: start at 250, done at 4 --------
        rec_ready = 1'b0;
        ap_continue = 1'b1;
        do_reset();
        to_ts(250);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        to_ts(260);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t7_w8_valid", {31'd0, rec8_valid}, 32'd1);
        check("t7_w8_start", {24'd0, rec8_start_ts}, 32'd250);
        check("t7_w8_lat", {24'd0, rec8_latency}, 32'd10);
        check("t7_w8_id", {16'd0, rec8_id}, 32'd0);
        check("t7_w32_lat", rec_latency, 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_txn_recorder.md
AP_CTRL_TXN_RECORDER -- requirements
Module: ap_ctrl_txn_recorder

Interface
REQ-001 Parameter TS_W, default 32, width of the timestamp and latency fields.
REQ-002 Parameter DEPTH, default 4, record FIFO depth; SHALL be a power of 2, at least 2.
REQ-003 clock  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ap_start  in  1  start of the observed ap_ctrl_hs module.
REQ-006 ap_done  in  1  done of the observed module.
REQ-007 ap_continue  in  1  continue of the observed module; tie to 1 when the module has none.
REQ-008 rec_ready  in  1  downstream consumer accepts the head record.
REQ-009 rec_valid  out  1  head record present (FIFO not empty).
REQ-010 rec_start_ts  out  TS_W  timestamp of the transaction start.
REQ-011 rec_latency  out  TS_W  cycles from start to first ap_done.
REQ-012 rec_id  out  16  transaction sequence number, wraps at 0xFFFF to 0.
REQ-013 busy  out  1  high in RUN or HOLD.
REQ-014 drop_cnt  out  16  records dropped because the FIFO was full; saturates at 0xFFFF.

Function
REQ-015 Free-running counter ts: 0 in the first cycle after reset deasserts, +1 per cycle, wraps modulo 2^TS_W.
REQ-016 FSM states: IDLE, RUN, HOLD.
REQ-017 IDLE, ap_start=1 and ap_done=0: capture start_ts=ts and go to RUN.
REQ-018 IDLE, ap_start=1 and ap_done=1 in the same cycle: latency 0; push if ap_continue=1 (stay IDLE), else go to HOLD.
REQ-019 RUN, ap_done=1: latch latency=(ts-start_ts) mod 2^TS_W; if ap_continue=1, push and go to IDLE, else go to HOLD.
REQ-020 HOLD: latency stays frozen; when ap_continue=1, push and go to IDLE.
REQ-021 A new start is sampled only in IDLE, so ap_start held high gives back-to-back starts one cycle after each push.
REQ-022 On every push attempt, rec_id takes the value of the transaction counter, which then increments; dropped records still consume an id.
REQ-023 A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle; otherwise the record is dropped and drop_cnt increments.
REQ-024 Pop occurs when rec_valid=1 and rec_ready=1; outputs show the next entry in the following cycle.
REQ-025 Push-to-visibility latency: a record pushed in cycle N is presented on rec_valid no earlier than cycle N+1; there is no combinational bypass.
REQ-026 Pop on an empty FIFO SHALL have no effect.
REQ-027 Record outputs SHALL be held stable while rec_valid=1 and rec_ready=0.

Reset
REQ-028 Reset SHALL force: FSM to IDLE; ts, start_ts, latency and the id counter to 0; FIFO empty; rec_valid=0; busy=0; drop_cnt=0; rec_start_ts/rec_latency/rec_id=0.
REQ-029 Reset asserted mid-transaction SHALL discard the in-flight transaction and all queued records, with no push.

Configuration
REQ-030 Macro AP_CTRL_TXN_RECORDER_INTERVAL_EN.
- Defined: adds output rec_interval (TS_W bits) = start_ts minus the previous transaction's start_ts, modulo 2^TS_W; 0 for the first transaction after reset; stored per FIFO entry.
- Undefined: the port, the storage and the previous-start register are absent; all other behaviour is identical.

Verification
REQ-031 Reset release, ap_start=1 at ts=5, ap_done=1 at ts=12, ap_continue=1, rec_ready=1 -> one record: start_ts=5, latency=7, id=0; busy low from the next cycle.
REQ-032 Same start at ts=5, ap_done at ts=12 with ap_continue=0 until ts=15 -> push at ts=15, latency=7, busy high through ts=15.
REQ-033 rec_ready=0, DEPTH=4, six 3-cycle transactions -> four records queued, drop_cnt=2, ids 0..3 retained; then rec_ready=1 drains ids 0,1,2,3 in order.
REQ-034 FIFO full with push and pop in the same cycle -> push accepted, drop_cnt unchanged, rec_valid stays 1.
REQ-035 TS_W=8, start at ts=250, done at ts=4 (after wrap) -> latency=10.
REQ-036 Reset pulsed while in RUN with 2 records queued -> rec_valid=0, busy=0, drop_cnt=0 next cycle; the next transaction gets id 0; with the macro defined, its interval=0.
